// File: rtl/antirrebote_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : antirrebote_pkg                                               |
// | Purpose  : Shared defaults and per-button FSM state encoding for the     |
// |            push-button conditioning stage (antirrebote_botones).         |
// | Contents : DEBOUNCE_CYCLES_DEF, REPEAT_DELAY_DEF, REPEAT_PERIOD_DEF,     |
// |            REPEAT_EN_DEF, CNT_W_DEF, btn_state_e                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package antirrebote_pkg;

  // Defaults assume a 100 MHz clock: 10 ms debounce, 500 ms repeat delay,
  // 200 ms repeat period.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int unsigned REPEAT_DELAY_DEF    = 50000000;
  localparam int unsigned REPEAT_PERIOD_DEF   = 20000000;
  localparam int unsigned REPEAT_EN_DEF       = 1;
  localparam int unsigned CNT_W_DEF           = 26;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } btn_state_e;

endpackage : antirrebote_pkg
`default_nettype wire

// File: rtl/antirrebote_botones_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : debouncer_boton                                               |
// | Purpose  : One raw push-button bit: 2-flop synchroniser followed by a    |
// |            consecutive-cycle debounce counter.                           |
// | Ports    : clk       in  system clock                                    |
// |            rst       in  asynchronous active-low reset                   |
// |            btn_raw   in  raw asynchronous button level                   |
// |            btn_level out debounced level, registered                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module debouncer_boton
  import antirrebote_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level
);

  localparam logic [CNT_W-1:0] C_DEB_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter measures how long the synchronised input has disagreed with
  // the accepted level; any agreement restarts the measurement, so a bounce
  // shorter than DEBOUNCE_CYCLES never flips the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == C_DEB_TERM) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_level = level_q;

endmodule : debouncer_boton
`default_nettype wire

// File: rtl/antirrebote_botones.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : antirrebote_botones                                           |
// | Purpose  : Conditions the two frequency-selector push buttons: sync,     |
// |            debounce, single-cycle press pulse, hold-to-auto-repeat and   |
// |            a lock-out whenever both buttons are held together.           |
// | Ports    : clk       in  system clock (100 MHz)                          |
// |            rst       in  asynchronous active-low reset                   |
// |            EN        in  pulse enable, 0 suppresses all pulses           |
// |            btn_in    in  [1]=up, [0]=down, raw active-high levels        |
// |            botones   out one-cycle registered pulses, never 2'b11        |
// |            btn_level out debounced levels, registered                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module antirrebote_botones
  import antirrebote_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
  parameter int unsigned REPEAT_EN       = REPEAT_EN_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EN,
  input  logic [1:0] btn_in,
  output logic [1:0] botones,
  output logic [1:0] btn_level
);

  localparam logic [CNT_W-1:0] C_DELAY_TERM  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] C_PERIOD_TERM = CNT_W'(REPEAT_PERIOD - 1);

  logic [1:0] level_w;
  logic [1:0] level_prev_q;
  logic [1:0] botones_d;
  logic [1:0] botones_q;

  for (genvar i = 0; i < 2; i++) begin : g_deb
    debouncer_boton #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn_in[i]),
      .btn_level (level_w[i])
    );
  end

  for (genvar i = 0; i < 2; i++) begin : g_fsm
    btn_state_e       state_q;
    btn_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_d;
    logic             rise_w;

    // Only a fresh debounced edge arms the FSM. A level that is already high
    // when EN returns, when a lock ends or when the FSM was forced idle does
    // not count as a press.
    assign rise_w = level_w[i] & ~level_prev_q[i];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      if (!EN || !level_w[i]) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (level_w[1-i]) begin
        // Both buttons held: neither may pulse until this one is released.
        state_d = LOCK;
        cnt_d   = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise_w) begin
              state_d = HOLD;
              cnt_d   = '0;
              pulse_d = 1'b1;
            end
          end
          HOLD: begin
            if (cnt_q == C_DELAY_TERM) begin
              // With auto-repeat disabled the counter parks at its terminal
              // value and the FSM waits for the release.
              if (REPEAT_EN != 0) begin
                state_d = REPEAT;
                cnt_d   = '0;
                pulse_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          REPEAT: begin
            if (cnt_q == C_PERIOD_TERM) begin
              cnt_d   = '0;
              pulse_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          LOCK: begin
            state_d = LOCK;
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign botones_d[i] = pulse_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      botones_q    <= 2'b00;
      level_prev_q <= 2'b00;
    end else begin
      botones_q    <= botones_d;
      level_prev_q <= level_w;
    end
  end

  assign botones   = botones_q;
  assign btn_level = level_w;

endmodule : antirrebote_botones
`default_nettype wire

// File: tb/tb_antirrebote_botones.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_antirrebote_botones                                        |
// | Purpose  : Self-checking bench for antirrebote_botones: directed cases   |
// |            plus randomized button activity against a behavioural model.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_antirrebote_botones;

  localparam int T_DEB = 4;
  localparam int T_RD  = 20;
  localparam int T_RP  = 8;
  localparam int T_REN = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       EN  = 1'b0;
  logic [1:0] btn_in = 2'b00;
  logic [1:0] botones;
  logic [1:0] btn_level;

  antirrebote_botones #(
    .DEBOUNCE_CYCLES (T_DEB),
    .REPEAT_DELAY    (T_RD),
    .REPEAT_PERIOD   (T_RP),
    .REPEAT_EN       (T_REN),
    .CNT_W           (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .EN        (EN),
    .btn_in    (btn_in),
    .botones   (botones),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, $signed(got), $signed(exp));
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [1:0] m_sync_dly[$];   // raw samples in flight through the synchroniser
  int         m_run[2];        // consecutive edges the synced input disagreed
  logic [1:0] m_lvl;
  logic [1:0] m_prev;
  logic [1:0] m_bot;
  bit         m_active[2];
  bit         m_locked[2];
  int         m_t0[2];         // edge number of the press pulse
  int         m_edge;

  task automatic model_reset();
    m_sync_dly.delete();
    m_sync_dly.push_back(2'b00);
    m_sync_dly.push_back(2'b00);
    m_lvl  = 2'b00;
    m_prev = 2'b00;
    m_bot  = 2'b00;
    m_edge = 0;
    for (int i = 0; i < 2; i++) begin
      m_run[i]    = 0;
      m_active[i] = 0;
      m_locked[i] = 0;
      m_t0[i]     = 0;
    end
  endtask

  task automatic model_step();
    logic [1:0] s;
    logic [1:0] lvl_pre;
    logic [1:0] prev_pre;
    int         e;
    s = m_sync_dly.pop_front();
    m_sync_dly.push_back(btn_in);
    lvl_pre  = m_lvl;
    prev_pre = m_prev;
    m_edge++;
    m_bot = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (!EN || !lvl_pre[i]) begin
        m_active[i] = 0;
        m_locked[i] = 0;
      end else if (lvl_pre[1-i]) begin
        m_active[i] = 0;
        m_locked[i] = 1;
      end else if (m_locked[i]) begin
        m_locked[i] = 1;
      end else if (!m_active[i]) begin
        if (!prev_pre[i]) begin
          m_active[i] = 1;
          m_t0[i]     = m_edge;
          m_bot[i]    = 1'b1;
        end
      end else begin
        e = m_edge - m_t0[i];
        if (T_REN != 0 && e >= T_RD && ((e - T_RD) % T_RP) == 0) m_bot[i] = 1'b1;
      end
    end
    m_prev = lvl_pre;
    for (int i = 0; i < 2; i++) begin
      if (s[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == T_DEB) begin
          m_lvl[i] = ~m_lvl[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  // ---------------- per-phase observation counters ----------------
  int ph_cyc;
  int ph_pulses;
  int ph_first_pulse;
  int ph_first_lvl;

  task automatic phase_start();
    ph_cyc         = 0;
    ph_pulses      = 0;
    ph_first_pulse = -1;
    ph_first_lvl   = -1;
  endtask

  // Entered at a falling edge: drive, let one rising edge pass, check at the
  // next falling edge.
  task automatic cycle(input logic [1:0] b, input logic en);
    btn_in = b;
    EN     = en;
    @(posedge clk);
    if (!rst) model_reset();
    else      model_step();
    @(negedge clk);
    check("botones", {30'd0, botones}, {30'd0, m_bot});
    check("btn_level", {30'd0, btn_level}, {30'd0, m_lvl});
    ph_cyc++;
    if (botones != 2'b00) begin
      ph_pulses++;
      if (ph_first_pulse < 0) ph_first_pulse = ph_cyc;
    end
    if (btn_level != 2'b00 && ph_first_lvl < 0) ph_first_lvl = ph_cyc;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(2'b00, 1'b1);
  endtask

  task automatic hold(input logic [1:0] b, input logic en, input int n);
    for (int k = 0; k < n; k++) cycle(b, en);
  endtask

  // Called at a falling edge; leaves rst low for the following rising edge.
  task automatic async_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_botones", {30'd0, botones}, 32'd0);
    check("rst_btn_level", {30'd0, btn_level}, 32'd0);
  endtask

  initial begin
    model_reset();
    phase_start();

    // 1. reset with both buttons pressed, then release
    hold(2'b11, 1'b1, 3);
    check("t1_rst_pulses", ph_pulses, 0);
    check("t1_rst_level", {30'd0, btn_level}, 32'd0);
    rst = 1'b1;
    phase_start();
    idle(10);
    check("t1_idle_pulses", ph_pulses, 0);

    // 2. clean press of the up button
    phase_start();
    hold(2'b10, 1'b1, 40);
    check("t2_level_edge", ph_first_lvl, 6);
    check("t2_first_pulse", ph_first_pulse, 7);
    check("t2_pulse_count", ph_pulses, 3);
    idle(15);

    // 3. bouncing down button, then settles high
    phase_start();
    for (int k = 0; k < 20; k++) cycle(((k / 2) % 2 == 0) ? 2'b01 : 2'b00, 1'b1);
    check("t3_bounce_pulses", ph_pulses, 0);
    check("t3_bounce_level", ph_first_lvl, -1);
    phase_start();
    hold(2'b01, 1'b1, 25);
    check("t3_settle_pulse", ph_first_pulse, 7);
    check("t3_settle_count", ph_pulses, 1);
    idle(15);

    // 4. both pressed, partial release, then a single press
    phase_start();
    hold(2'b11, 1'b1, 50);
    check("t4_both_level", {30'd0, btn_level}, 32'd3);
    hold(2'b01, 1'b1, 20);
    check("t4_lock_pulses", ph_pulses, 0);
    idle(15);
    phase_start();
    hold(2'b01, 1'b1, 15);
    check("t4_press_count", ph_pulses, 1);
    check("t4_press_edge", ph_first_pulse, 7);
    idle(15);

    // 5. EN gating
    phase_start();
    hold(2'b10, 1'b0, 30);
    check("t5_en0_level", {30'd0, btn_level}, 32'd2);
    hold(2'b10, 1'b1, 30);
    check("t5_en_rise_pulses", ph_pulses, 0);
    idle(15);
    phase_start();
    hold(2'b10, 1'b1, 15);
    check("t5_repress_count", ph_pulses, 1);
    idle(15);

    // 6. reset while auto-repeating
    phase_start();
    hold(2'b01, 1'b1, 40);
    check("t6_repeat_count", ph_pulses, 3);
    async_reset();
    cycle(2'b01, 1'b1);
    rst = 1'b1;
    phase_start();
    hold(2'b01, 1'b1, 15);
    check("t6_level_edge", ph_first_lvl, 6);
    check("t6_fresh_pulse", ph_first_pulse, 7);
    check("t6_fresh_count", ph_pulses, 1);
    idle(15);

    // 7. randomized activity against the model
    for (int seg = 0; seg < 60; seg++) begin
      logic [1:0] b;
      logic       en;
      int         len;
      b   = 2'($urandom_range(0, 3));
      en  = ($urandom_range(0, 7) != 0);
      len = $urandom_range(1, 40);
      if ($urandom_range(0, 15) == 0) begin
        async_reset();
        cycle(b, en);
        rst = 1'b1;
      end
      hold(b, en, len);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_antirrebote_botones
`default_nettype wire
